// File: rtl/pt_tx_sched.sv
// pt_tx_sched -- transmit scheduler between the UART word assembler and the
// PT2262 encoder. Complete code words are queued. Each word is loaded into
// the encoder and sent REPEAT times, with GAP idle cycles after every frame.
// A stuck encoder is caught by a per-frame timeout.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_word/in_valid/in_ready   word push interface (pushes while full are dropped)
//   abort           one-cycle flush request
//   enc_ad/enc_ld   word and one-cycle load strobe to the encoder
//   enc_done        frame-complete indication from the encoder
//   busy            scheduler active or queue not empty
//   word_sent       one-cycle pulse after the last frame and gap of a word
//   err_timeout     sticky encoder timeout flag (cleared by abort)
module pt_tx_sched #(
  parameter int W       = 24,
  parameter int DEPTH   = 4,
  parameter int REPEAT  = 4,
  parameter int GAP     = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [W-1:0] enc_ad,
  output logic         enc_ld,
  input  logic         enc_done,
  output logic         busy,
  output logic         word_sent,
  output logic         err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(REPEAT) + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WAIT, ST_GAP, ST_DRAIN
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] rep;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wait_cnt;

  logic push, pop, flush, start_word, rep_inc, clr_wait, clr_gap, set_err, sent;

  // A push that coincides with abort is discarded along with the queue.
  assign push = in_valid && in_ready && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and control strobes
  always_comb begin
    state_next = state;
    start_word = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    rep_inc    = 1'b0;
    clr_wait   = 1'b0;
    clr_gap    = 1'b0;
    set_err    = 1'b0;
    sent       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (abort) flush = 1'b1;
        else if (count != '0) begin
          state_next = ST_LOAD;
          start_word = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
          clr_wait   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = ST_DRAIN;
        // wait_cnt == 0 is the first WAIT cycle: a done still high from the
        // previous frame must not be taken as completion of this one.
        end else if (enc_done && wait_cnt != '0) begin
          state_next = ST_GAP;
          clr_gap    = 1'b1;
        end else if (wait_cnt == TMO_LAST) begin
          set_err    = 1'b1;
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = ST_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          if (rep != REP_LAST) begin
            rep_inc    = 1'b1;
            state_next = ST_LOAD;
          end else begin
            pop        = 1'b1;
            sent       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // The encoder frame in flight cannot be cut short; wait it out.
        if (abort) flush = 1'b1;
        else if (enc_done || wait_cnt == TMO_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    enc_ld   = (state == ST_LOAD) && !abort;
    busy     = (state != ST_IDLE) || (count != '0);
    in_ready = (count != CNT_FULL);
  end

  // Queue storage: no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Repeat, gap and wait counters plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep         <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      enc_ad      <= '0;
      word_sent   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (start_word)   rep <= '0;
      else if (rep_inc) rep <= rep + RW'(1);

      if (clr_gap) gap_cnt <= '0;
      else if (state == ST_GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GW'(1);

      // Keeps counting through DRAIN so the abort path shares the frame deadline.
      if (clr_wait) wait_cnt <= '0;
      else if ((state == ST_WAIT || state == ST_DRAIN) && wait_cnt != TMO_LAST)
        wait_cnt <= wait_cnt + TW'(1);

      // Head word is captured once per word and held across all repeats.
      if (start_word) enc_ad <= mem[rd_ptr];

      word_sent <= sent;

      if (flush)        err_timeout <= 1'b0;
      else if (set_err) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pt_tx_sched.sv
// Testbench for pt_tx_sched: directed tests against a timeline model of the
// scheduler plus literal expectations on enc_ld spacing, word order and flags.
module tb_pt_tx_sched;
  localparam int W = 24, DEPTH = 4, REPEAT = 4, GAP = 32, TIMEOUT = 4096;
  localparam int PERIOD = 100 + 1 + GAP;  // ld-to-ld spacing with a 100-cycle encoder

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_word = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [W-1:0] enc_ad;
  logic         enc_ld;
  logic         enc_done;
  logic         busy;
  logic         word_sent;
  logic         err_timeout;

  always #5 clk = ~clk;

  pt_tx_sched #(.W(W), .DEPTH(DEPTH), .REPEAT(REPEAT), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .enc_ad(enc_ad), .enc_ld(enc_ld), .enc_done(enc_done), .busy(busy),
    .word_sent(word_sent), .err_timeout(err_timeout)
  );

  // Encoder model: done is a one-cycle pulse enc_dly cycles after the ld cycle.
  // enc_dly = 0 means done never comes.
  int enc_dly = 100;
  int dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dcnt <= 0;
    else if (enc_ld)      dcnt <= enc_dly;
    else if (dcnt > 0)    dcnt <= dcnt - 1;
  end
  always_comb enc_done = (dcnt == 1);

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Edge counter shared by the bench
  int tb_cyc = 0;
  initial forever begin
    @(posedge clk);
    tb_cyc++;
  end

  // Timeline model: each word starts at edge t_ld; a frame's done is accepted
  // from t_ld+3 on, timeout hits at t_ld+1+TIMEOUT, next frame at done+GAP.
  logic [W-1:0] mq[$];
  int m_act = 0;  // 0 idle, 1 word in progress, 2 draining after abort
  int m_cyc = 0, m_tld = 0, m_tdone = -1, m_frames = 0, m_tsent = -1;
  logic [W-1:0] m_ad = '0;
  logic m_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_cyc = 0; m_tld = 0; m_tdone = -1; m_frames = 0; m_tsent = -1;
      m_ad = '0; m_err = 1'b0;
    end else begin
      bit acc;
      m_cyc++;
      acc = in_valid && (mq.size() != DEPTH) && !abort;
      if (abort) begin
        mq.delete();
        m_err = 1'b0;
        if (m_act == 1) m_act = (m_tdone < 0 && m_cyc >= m_tld + 2) ? 2 : 0;
      end else begin
        case (m_act)
          0: if (mq.size() != 0) begin
               m_act = 1; m_ad = mq[0]; m_tld = m_cyc; m_tdone = -1; m_frames = 0;
             end
          1: if (m_tdone < 0) begin
               if (m_cyc >= m_tld + 3 && enc_done) m_tdone = m_cyc;
               else if (m_cyc == m_tld + 1 + TIMEOUT) begin
                 m_err = 1'b1; void'(mq.pop_front()); m_act = 0;
               end
             end else if (m_cyc == m_tdone + GAP) begin
               if (m_frames < REPEAT - 1) begin
                 m_frames++; m_tld = m_cyc; m_tdone = -1;
               end else begin
                 void'(mq.pop_front()); m_act = 0; m_tsent = m_cyc;
               end
             end
          default: if (enc_done || m_cyc >= m_tld + 1 + TIMEOUT) m_act = 0;
        endcase
      end
      if (acc) mq.push_back(in_word);
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("cmp_enc_ld", 32'(enc_ld), 32'(m_act == 1 && m_cyc == m_tld && !abort));
    chk("cmp_enc_ad", 32'(enc_ad), 32'(m_ad));
    chk("cmp_word_sent", 32'(word_sent), 32'(m_tsent == m_cyc));
    chk("cmp_busy", 32'(busy), 32'(m_act != 0 || mq.size() != 0));
    chk("cmp_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("cmp_err_timeout", 32'(err_timeout), 32'(m_err));
  end

  // Observation logs for the literal checks
  int ld_t[$];
  logic [W-1:0] ld_ad[$];
  int n_sent = 0, n_notready = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (enc_ld) begin
        ld_t.push_back(tb_cyc);
        ld_ad.push_back(enc_ad);
      end
      if (word_sent) n_sent++;
      if (!in_ready) n_notready++;
    end
  end

  task automatic clear_logs();
    ld_t.delete(); ld_ad.delete(); n_sent = 0; n_notready = 0;
  endtask

  task automatic push(input logic [W-1:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_word  = w;
  endtask

  task automatic release_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < budget), 32'd1);
  endtask

  task automatic check_frames(input string nm, input int nwords, input logic [W-1:0] base);
    chk({nm, "_ld_count"}, 32'(ld_t.size()), 32'(nwords * REPEAT));
    for (int i = 1; i < ld_t.size(); i++)
      if (i % REPEAT != 0) chk({nm, "_spacing"}, 32'(ld_t[i] - ld_t[i-1]), 32'(PERIOD));
    for (int i = 0; i < ld_ad.size(); i++)
      chk({nm, "_ad"}, 32'(ld_ad[i]), 32'(base + W'(i / REPEAT)));
    chk({nm, "_sent"}, 32'(n_sent), 32'(nwords));
  endtask

  initial begin
    int t_push, t_err, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_enc_ad", 32'(enc_ad), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single word, four frames
    clear_logs();
    @(posedge clk); #1;
    in_valid = 1'b1; in_word = 24'hAAAA01; t_push = tb_cyc;
    release_in();
    wait_idle(1000, "t1_idle");
    check_frames("t1", 1, 24'hAAAA01);
    if (ld_t.size() > 0) chk("t1_latency", 32'(ld_t[0] - t_push), 32'd2);
    chk("t1_last_spacing", 32'(ld_t.size() == 4 ? ld_t[3] - ld_t[0] : 0), 32'(3 * PERIOD));

    // 2: three words back to back, queue never fills
    clear_logs();
    push(24'h000001); push(24'h000002); push(24'h000003);
    release_in();
    wait_idle(2500, "t2_idle");
    check_frames("t2", 3, 24'h000001);
    chk("t2_never_full", 32'(n_notready), 32'd0);

    // 3: five words, the fifth is dropped
    clear_logs();
    push(24'h000010); push(24'h000011); push(24'h000012); push(24'h000013); push(24'h000014);
    release_in();
    wait_idle(3000, "t3_idle");
    check_frames("t3", 4, 24'h000010);
    chk("t3_saw_full", 32'(n_notready > 0), 32'd1);

    // 4: encoder stuck, timeout then the next word still goes out
    clear_logs();
    enc_dly = 0;
    push(24'h0000C1); push(24'h0000C2);
    release_in();
    n = 0;
    while (!err_timeout && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    t_err = tb_cyc;
    enc_dly = 100;
    chk("t4_err_set", 32'(err_timeout), 32'd1);
    if (ld_t.size() > 0) chk("t4_tmo_time", 32'(t_err - ld_t[0]), 32'(TIMEOUT + 1));
    chk("t4_no_sent_on_tmo", 32'(n_sent), 32'd0);
    wait_idle(1000, "t4_idle");
    chk("t4_ld_count", 32'(ld_t.size()), 32'd5);
    if (ld_t.size() == 5) chk("t4_next_word", 32'(ld_ad[1]), 32'h0000C2);
    chk("t4_sent", 32'(n_sent), 32'd1);
    chk("t4_err_sticky", 32'(err_timeout), 32'd1);
    @(posedge clk); #1; abort = 1'b1;
    release_in();
    @(negedge clk);
    chk("t4_abort_clears_err", 32'(err_timeout), 32'd0);

    // 5: abort during WAIT of the second frame with two words queued behind
    clear_logs();
    push(24'h000051); push(24'h000052); push(24'h000053);
    release_in();
    n = 0;
    while (ld_t.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_second_ld", 32'(ld_t.size()), 32'd2);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    release_in();
    repeat (5) @(negedge clk);
    chk("t5_drain_busy", 32'(busy), 32'd1);
    repeat (300) @(negedge clk);
    chk("t5_no_more_ld", 32'(ld_t.size()), 32'd2);
    chk("t5_no_sent", 32'(n_sent), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_empty", 32'(in_ready), 32'd1);

    // 6: asynchronous reset in the middle of a gap
    clear_logs();
    push(24'h000066);
    release_in();
    n = 0;
    while (ld_t.size() < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (110) @(posedge clk);
    #3;
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_enc_ad", 32'(enc_ad), 32'd0);
    chk("t6_rst_enc_ld", 32'(enc_ld), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_word_sent", 32'(word_sent), 32'd0);
    chk("t6_rst_err", 32'(err_timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    push(24'h000077);
    release_in();
    wait_idle(1000, "t6_idle");
    check_frames("t6", 1, 24'h000077);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
